// File: rtl/mem_port_arbiter_if.sv
// ============================================================================
// Module   : mem_port_arbiter_if
// Brief    : Requester and SRAM-side bundle for the shared-memory arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface mem_port_arbiter_if #(
    parameter int NPORTS = 4,
    parameter int AW     = 4,
    parameter int DW     = 8
);
    logic [NPORTS-1:0]    req;
    logic [NPORTS-1:0]    rw;
    logic [NPORTS*AW-1:0] addr;
    logic [NPORTS*DW-1:0] wdata;
    logic [NPORTS-1:0]    gnt;
    logic [NPORTS-1:0]    rvalid;
    logic [DW-1:0]        rdata;
    logic                 mem_en;
    logic                 mem_we;
    logic [AW-1:0]        mem_addr;
    logic [DW-1:0]        mem_wdata;
    logic [DW-1:0]        mem_rdata;
    logic                 low_power;

    // Requesters plus the SRAM macro sit on the master side.
    modport master (
        output req, rw, addr, wdata, mem_rdata,
        input  gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata, low_power
    );

    modport slave (
        input  req, rw, addr, wdata, mem_rdata,
        output gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata, low_power
    );
endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Round-robin arbiter/sequencer sharing one single-port SRAM, with
//            idle-timeout low-power state.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
    parameter int NPORTS  = 4,
    parameter int AW      = 4,
    parameter int DW      = 8,
    parameter int TIMEOUT = 10
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.slave  bus
);

    localparam int PW = $clog2(NPORTS);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ACCESS    = 2'd1,
        S_READ_WAIT = 2'd2,
        S_LOW_POWER = 2'd3
    } state_t;

    state_t            r_state;
    logic [PW-1:0]     r_rr_ptr;
    logic [PW-1:0]     r_winner;
    logic [CW-1:0]     r_idle_cnt;
    logic [NPORTS-1:0] r_gnt;
    logic [NPORTS-1:0] r_rvalid;
    logic [DW-1:0]     r_rdata;
    logic              r_mem_en;
    logic              r_mem_we;
    logic [AW-1:0]     r_mem_addr;
    logic [DW-1:0]     r_mem_wdata;
    logic              r_low_power;

    logic              w_found;
    logic [PW-1:0]     w_winner;
    logic [PW:0]       w_cand;

    // Search upward from the port after the last winner, wrapping at NPORTS.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_cand   = '0;
        for (int i = 1; i <= NPORTS; i++) begin
            w_cand = {1'b0, r_rr_ptr} + (PW+1)'(i);
            if (w_cand >= (PW+1)'(NPORTS)) begin
                w_cand = w_cand - (PW+1)'(NPORTS);
            end
            if (!w_found && bus.req[w_cand[PW-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_cand[PW-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= PW'(NPORTS - 1);
            r_winner    <= '0;
            r_idle_cnt  <= '0;
            r_gnt       <= '0;
            r_rvalid    <= '0;
            r_rdata     <= '0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_low_power <= 1'b0;
        end else begin
            r_gnt    <= '0;
            r_rvalid <= '0;
            r_mem_en <= 1'b0;
            r_mem_we <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_state           <= S_ACCESS;
                        r_rr_ptr          <= w_winner;
                        r_winner          <= w_winner;
                        r_idle_cnt        <= '0;
                        r_gnt[w_winner]   <= 1'b1;
                        r_mem_en          <= 1'b1;
                        r_mem_we          <= bus.rw[w_winner];
                        r_mem_addr        <= bus.addr[w_winner*AW +: AW];
                        r_mem_wdata       <= bus.wdata[w_winner*DW +: DW];
                    end else if (TIMEOUT != 0 && r_idle_cnt == CW'(TIMEOUT)) begin
                        r_state     <= S_LOW_POWER;
                        r_low_power <= 1'b1;
                        r_idle_cnt  <= '0;
                    end else if (TIMEOUT != 0) begin
                        r_idle_cnt <= r_idle_cnt + CW'(1);
                    end
                end
                S_ACCESS: begin
                    r_state <= r_mem_we ? S_IDLE : S_READ_WAIT;
                end
                S_READ_WAIT: begin
                    r_rdata            <= bus.mem_rdata;
                    r_rvalid[r_winner] <= 1'b1;
                    r_state            <= S_IDLE;
                end
                S_LOW_POWER: begin
                    // Waking costs one cycle; the request is arbitrated from IDLE.
                    if (|bus.req) begin
                        r_state     <= S_IDLE;
                        r_low_power <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt       = r_gnt;
    assign bus.rvalid    = r_rvalid;
    assign bus.rdata     = r_rdata;
    assign bus.mem_en    = r_mem_en;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.low_power = r_low_power;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Directed and random stimulus for mem_port_arbiter against a
//            cycle-budget transaction model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

    localparam int NP = 4;
    localparam int AW = 4;
    localparam int DW = 8;
    localparam int TO = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;

    mem_port_arbiter_if #(.NPORTS(NP), .AW(AW), .DW(DW)) bus ();

    mem_port_arbiter #(.NPORTS(NP), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Behavioural SRAM macro: one-cycle read latency.
    logic [DW-1:0] sram [2**AW];
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) sram[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata      <= sram[bus.mem_addr];
        end
    end

    int checks;
    int errors;

    // Transaction model: arbitration allowed at edge next_free, reads return
    // two edges after their grant, writes occupy two edges, reads three.
    int            t;
    int            next_free;
    int            rr;
    int            idle;
    int            rv_edge;
    int            rv_port;
    bit            in_lp;
    bit            rv_pend;
    logic [DW-1:0] rv_data;
    logic [DW-1:0] mdl_mem [2**AW];
    logic [NP-1:0] exp_gnt;
    logic [NP-1:0] exp_rv;
    logic [DW-1:0] exp_rdata;
    logic [DW-1:0] exp_wdata;
    logic [AW-1:0] exp_addr;
    logic          exp_we;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, exp, t);
        end
    endtask

    task automatic model_reset();
        rr        = NP - 1;
        idle      = 0;
        in_lp     = 1'b0;
        rv_pend   = 1'b0;
        next_free = t + 1;
        exp_gnt   = '0;
        exp_rv    = '0;
        exp_rdata = '0;
        exp_wdata = '0;
        exp_addr  = '0;
        exp_we    = 1'b0;
    endtask

    task automatic model_edge();
        int            w;
        logic [NP-1:0] rq;
        t++;
        rq      = bus.req;
        exp_gnt = '0;
        exp_rv  = '0;
        if (rv_pend && t == rv_edge) begin
            exp_rv[rv_port] = 1'b1;
            exp_rdata       = rv_data;
            rv_pend         = 1'b0;
        end
        if (in_lp) begin
            if (rq != '0) begin
                in_lp     = 1'b0;
                next_free = t + 1;
            end
        end else if (t >= next_free) begin
            if (rq != '0) begin
                w = -1;
                for (int k = 1; k <= NP; k++) begin
                    if (w < 0 && rq[(rr + k) % NP]) w = (rr + k) % NP;
                end
                rr         = w;
                idle       = 0;
                exp_gnt[w] = 1'b1;
                exp_we     = bus.rw[w];
                exp_addr   = bus.addr[w*AW +: AW];
                exp_wdata  = bus.wdata[w*DW +: DW];
                if (exp_we) begin
                    mdl_mem[exp_addr] = exp_wdata;
                    next_free         = t + 2;
                end else begin
                    rv_pend   = 1'b1;
                    rv_edge   = t + 2;
                    rv_port   = w;
                    rv_data   = mdl_mem[exp_addr];
                    next_free = t + 3;
                end
            end else begin
                idle++;
                if (TO > 0 && idle == TO + 1) begin
                    in_lp = 1'b1;
                    idle  = 0;
                end
            end
        end
    endtask

    task automatic check_outputs();
        chk("gnt",       bus.gnt,       exp_gnt);
        chk("rvalid",    bus.rvalid,    exp_rv);
        chk("rdata",     bus.rdata,     exp_rdata);
        chk("mem_en",    bus.mem_en,    |exp_gnt);
        chk("mem_we",    bus.mem_we,    (|exp_gnt) ? exp_we : 1'b0);
        chk("mem_addr",  bus.mem_addr,  exp_addr);
        chk("mem_wdata", bus.mem_wdata, exp_wdata);
        chk("low_power", bus.low_power, in_lp);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk);
        t++;
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic set_port(input int i, input logic r, input logic w,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req[i]           = r;
        bus.rw[i]            = w;
        bus.addr[i*AW +: AW] = a;
        bus.wdata[i*DW +: DW] = d;
    endtask

    int rates [6] = '{50, 10, 0, 30, 3, 80};

    initial begin
        checks    = 0;
        errors    = 0;
        t         = 0;
        bus.req   = '0;
        bus.rw    = '0;
        bus.addr  = '0;
        bus.wdata = '0;
        for (int i = 0; i < 2**AW; i++) begin
            sram[i]    = '0;
            mdl_mem[i] = '0;
        end
        @(posedge clk);
        #1;
        do_reset();

        // Port 0 write then read-back.
        set_port(0, 1'b1, 1'b1, 4'd3, 8'hA5);
        tick();
        chk("wr_gnt",  bus.gnt, 4'b0001);
        chk("wr_we",   bus.mem_we, 1'b1);
        chk("wr_addr", bus.mem_addr, 4'd3);
        chk("wr_data", bus.mem_wdata, 8'hA5);
        bus.req[0] = 1'b0;
        tick();
        set_port(0, 1'b1, 1'b0, 4'd3, 8'h00);
        tick();
        bus.req[0] = 1'b0;
        tick();
        tick();
        chk("rd_rvalid", bus.rvalid, 4'b0001);
        chk("rd_data",   bus.rdata, 8'hA5);

        // All four ports reading, requests held continuously.
        do_reset();
        for (int i = 0; i < NP; i++) set_port(i, 1'b1, 1'b0, AW'(i + 4), 8'h00);
        for (int n = 0; n < 6; n++) begin
            tick();
            chk("rr_gnt", bus.gnt, 32'd1 << (n % NP));
            tick();
            tick();
            chk("rr_rvalid", bus.rvalid, 32'd1 << (n % NP));
        end
        bus.req = '0;
        tick();

        // Idle timeout into low power, then wake on a port 2 read.
        do_reset();
        repeat (TO) tick();
        chk("lp_before", bus.low_power, 1'b0);
        tick();
        chk("lp_enter", bus.low_power, 1'b1);
        repeat (3) tick();
        set_port(2, 1'b1, 1'b0, 4'd5, 8'h00);
        tick();
        chk("lp_wake",    bus.low_power, 1'b0);
        chk("wake_nognt", bus.gnt, 4'b0000);
        tick();
        chk("wake_gnt", bus.gnt, 4'b0100);
        bus.req[2] = 1'b0;
        repeat (3) tick();

        // Request arriving on the timeout edge wins over low power.
        do_reset();
        repeat (TO) tick();
        set_port(1, 1'b1, 1'b1, 4'd7, 8'h3C);
        tick();
        chk("race_gnt", bus.gnt, 4'b0010);
        chk("race_lp",  bus.low_power, 1'b0);
        bus.req[1] = 1'b0;
        repeat (2) tick();

        // Reset during READ_WAIT of a port 3 read.
        do_reset();
        set_port(3, 1'b1, 1'b0, 4'd3, 8'h00);
        tick();
        bus.req[3] = 1'b0;
        tick();
        do_reset();
        repeat (3) begin
            tick();
            chk("rst_norv", bus.rvalid, 4'b0000);
        end
        set_port(0, 1'b1, 1'b0, 4'd1, 8'h00);
        set_port(3, 1'b1, 1'b0, 4'd2, 8'h00);
        tick();
        chk("rst_prio", bus.gnt, 4'b0001);
        bus.req[0] = 1'b0;
        repeat (3) tick();
        chk("rst_next", bus.gnt, 4'b1000);
        bus.req[3] = 1'b0;
        repeat (3) tick();

        // Port 2 request withdrawn while another port holds the memory.
        set_port(0, 1'b1, 1'b1, 4'd9, 8'h77);
        tick();
        bus.req[0] = 1'b0;
        set_port(2, 1'b1, 1'b1, 4'd2, 8'h11);
        tick();
        bus.req[2] = 1'b0;
        repeat (3) begin
            tick();
            chk("wd_nognt", bus.gnt, 4'b0000);
            chk("wd_noen",  bus.mem_en, 1'b0);
        end

        // Random traffic with varying request density.
        for (int s = 0; s < 6; s++) begin
            for (int c = 0; c < 60; c++) begin
                tick();
                for (int i = 0; i < NP; i++) begin
                    if (exp_gnt[i]) begin
                        if ($urandom_range(1, 0) == 1)
                            set_port(i, 1'b1, 1'($urandom), AW'($urandom), DW'($urandom));
                        else
                            bus.req[i] = 1'b0;
                    end else if (!bus.req[i]) begin
                        if (int'($urandom_range(99, 0)) < rates[s])
                            set_port(i, 1'b1, 1'($urandom), AW'($urandom), DW'($urandom));
                    end else if ($urandom_range(39, 0) == 0) begin
                        bus.req[i] = 1'b0;
                    end
                end
            end
        end
        bus.req = '0;
        repeat (4) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Round-robin arbiter and sequencer sharing one synchronous single-port SRAM between NPORTS requesters.
- Each requester uses a req/gnt handshake; reads return data on a per-port rvalid pulse.
- Enters a low-power state after TIMEOUT consecutive idle cycles and wakes on any request.
- Sits between the CPU-side ports and the shared memory macro; replaces ad-hoc fixed-priority muxing.

Parameters:
- NPORTS, 4, number of requester ports (2..8).
- AW, 4, memory address width.
- DW, 8, data width.
- TIMEOUT, 10, consecutive idle cycles before LOW_POWER; 0 disables low power.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  NPORTS  per-port request.
- rw  in  NPORTS  per-port direction, 1 = write, 0 = read.
- addr  in  NPORTS*AW  per-port address; port i at bits [i*AW +: AW].
- wdata  in  NPORTS*DW  per-port write data; port i at bits [i*DW +: DW].
- gnt  out  NPORTS  one-hot grant pulse.
- rvalid  out  NPORTS  one-hot read-data-valid pulse.
- rdata  out  DW  read data, shared by all ports, qualified by rvalid.
- mem_en  out  1  SRAM access enable.
- mem_we  out  1  SRAM write enable.
- mem_addr  out  AW  SRAM address.
- mem_wdata  out  DW  SRAM write data.
- mem_rdata  in  DW  SRAM read data, valid one cycle after a read access.
- low_power  out  1  high while in LOW_POWER.

Behaviour:
- All outputs are registered. Reset values: gnt=0, rvalid=0, rdata=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, low_power=0. State=IDLE, rr_ptr=NPORTS-1, idle counter=0.
- States: IDLE, ACCESS, READ_WAIT, LOW_POWER.
- IDLE, any req high at an edge:
  - Winner = first port with req high, searching upward from rr_ptr+1 with wrap-around.
  - rr_ptr <= winner; go to ACCESS.
  - Winner's rw/addr/wdata are captured into mem_we/mem_addr/mem_wdata.
- ACCESS (exactly one cycle): gnt[winner]=1, mem_en=1, mem_we/mem_addr/mem_wdata hold the captured values.
  - Write: next state IDLE.
  - Read: next state READ_WAIT.
- READ_WAIT (one cycle): mem_en=0; mem_rdata is captured into rdata.
  - Next cycle rvalid[winner]=1 for one cycle, then state IDLE.
  - rdata holds its value until the next read capture.
- Timing, with request sampled at edge 0:
  - gnt visible in cycle 1.
  - Read data + rvalid visible in cycle 3.
  - Write throughput: one access per 2 cycles. Read throughput: one per 3 cycles.
  - The IDLE cycle in which rvalid is high may sample a new request.
- Requester protocol:
  - Hold req, rw, addr and wdata stable until gnt.
  - Dropping req before it is sampled withdraws the request; no access occurs.
  - req still high in the cycle after gnt is a new request.
- Outside ACCESS: mem_en=0 and mem_we=0. mem_addr/mem_wdata keep their last values.
- Idle counter:
  - Increments each IDLE cycle with req==0; clears on any req or on leaving IDLE.
  - When it reaches TIMEOUT with req==0, next state is LOW_POWER.
  - If req is high on that same edge, arbitration wins and LOW_POWER is not entered.
- LOW_POWER: low_power=1, mem_en=0.
  - Any req high moves to IDLE; low_power=0 from the next cycle. That costs one wake cycle, with arbitration in IDLE on the following edge.
  - The req must still be held to be served.
- Reset asserted mid-operation: immediately returns all outputs and state to reset values.
  - An in-flight read is dropped; no rvalid is ever issued for it.
  - rr_ptr returns to NPORTS-1, so port 0 has first priority after reset.
- Only one of gnt and one of rvalid may be high in any cycle. gnt and rvalid never target the same access in the same cycle.

Test Plan:
- Port0 write addr=3 wdata=0xA5 → gnt[0], mem_en=1, mem_we=1, mem_addr=3, mem_wdata=0xA5 in cycle 1. Then port0 read addr=3 → rvalid[0]=1 with rdata=0xA5 three cycles after its request is sampled.
- req=4'b1111, all reads, held continuously → grant order 0,1,2,3,0,1. Each grant 3 cycles apart; rvalid order matches.
- After reset, no req for 10 cycles → low_power=1 from cycle 11. Raise req[2] read → low_power=0 next cycle, gnt[2] one cycle later, mem_en=0 throughout LOW_POWER.
- req[1] rises on the edge where the idle count reaches 10 → no LOW_POWER; gnt[1] next cycle.
- Assert rst during READ_WAIT of a port3 read → no rvalid, all outputs 0. After release, req=4'b1001 → port0 granted first.
- req[2] raised then dropped before being sampled (in ACCESS of another port) → no gnt[2] and no memory access for port 2.
